// File: rtl/conv_row_sequencer.sv
// conv_row_sequencer: run-time-K control sequencer for the binary
// convolution engine (addressing, row/column counters, strobes).
module conv_row_sequencer #(
  parameter int          ADDR_W   = 12,
  parameter int          KMAX     = 5,
  parameter int          RD_LAT   = 2,
  parameter int          CONV_LAT = 2,
  parameter logic [15:0] END_MARK = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [15:0]       sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [15:0]       wmem_dut_read_data,
  output logic [2:0]        k_dim,
  output logic              weight_load,
  output logic              row_load,
  output logic              conv_go,
  output logic [3:0]        col_idx,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic              cfg_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_CHECK, S_FILL, S_SWEEP,
    S_DRAIN, S_WRITE, S_ADV, S_SKIP, S_NEXT
  } state_t;

  typedef struct packed {
    logic row;
    logic wbits;
    logic wk;
    logic ncols;
    logic nrows;
  } tag_t;

  localparam tag_t T_NONE = 5'b00000;
  localparam tag_t T_HDR0 = 5'b00101;
  localparam tag_t T_HDR1 = 5'b01010;
  localparam tag_t T_ROW  = 5'b10000;

  localparam logic [2:0] KMAX_K     = 3'(KMAX);
  localparam logic [7:0] DRAIN_LAST = 8'(CONV_LAT - 1);

  state_t            state;
  tag_t              tpipe [RD_LAT];
  tag_t              cur;
  logic              hcnt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] nxt_base;
  logic [ADDR_W-1:0] rptr;
  logic [15:0]       nrows;
  logic [15:0]       ncols;
  logic [15:0]       orow;
  logic [2:0]        icnt;
  logic [2:0]        lcnt;
  logic [3:0]        col_last;
  logic [7:0]        dcnt;
  logic              cfg_bad;
  logic              unused;

  // cur is the tag of the data on the read buses this cycle
  assign weight_load = cur.wbits;
  assign row_load    = cur.row;

  assign cfg_bad = (k_dim == 3'd0)
                || (k_dim > KMAX_K)
                || (ncols > 16'd16)
                || (16'(k_dim) > nrows)
                || (16'(k_dim) > ncols);

  assign unused = &{1'b0, wmem_dut_read_data[15:3]};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                  <= S_IDLE;
      for (int i = 0; i < RD_LAT; i++) tpipe[i] <= T_NONE;
      cur                    <= T_NONE;
      hcnt                   <= 1'b0;
      base                   <= '0;
      nxt_base               <= '0;
      rptr                   <= '0;
      nrows                  <= '0;
      ncols                  <= '0;
      orow                   <= '0;
      icnt                   <= '0;
      lcnt                   <= '0;
      col_last               <= '0;
      dcnt                   <= '0;
      dut_busy               <= 1'b0;
      dut_sram_read_address  <= '0;
      dut_wmem_read_address  <= '0;
      k_dim                  <= '0;
      conv_go                <= 1'b0;
      col_idx                <= '0;
      dut_sram_write_enable  <= 1'b0;
      dut_sram_write_address <= '0;
      cfg_err                <= 1'b0;
    end else begin
      tpipe[0] <= T_NONE;
      for (int i = 1; i < RD_LAT; i++) tpipe[i] <= tpipe[i-1];
      cur <= tpipe[RD_LAT-1];
      if (cur.wk) k_dim <= wmem_dut_read_data[2:0];

      unique case (state)
        S_IDLE: begin
          if (dut_run) begin
            dut_busy               <= 1'b1;
            base                   <= '0;
            dut_sram_read_address  <= '0;
            dut_wmem_read_address  <= '0;
            dut_sram_write_address <= '0;
            cfg_err                <= 1'b0;
            tpipe[0]               <= T_HDR0;
            hcnt                   <= 1'b1;
            state                  <= S_HDR;
          end
        end

        S_HDR: begin
          if (hcnt) begin
            dut_sram_read_address <= base + ADDR_W'(1);
            dut_wmem_read_address <= ADDR_W'(1);
            tpipe[0]              <= T_HDR1;
            hcnt                  <= 1'b0;
          end
          if (cur.nrows) begin
            if (sram_dut_read_data == END_MARK) begin
              // drop the header reads still in flight
              dut_busy <= 1'b0;
              state    <= S_IDLE;
              for (int i = 0; i < RD_LAT; i++) tpipe[i] <= T_NONE;
              cur      <= T_NONE;
            end else begin
              nrows    <= sram_dut_read_data;
              nxt_base <= base + ADDR_W'(2)
                        + ADDR_W'(sram_dut_read_data);
            end
          end
          if (cur.ncols) begin
            ncols <= sram_dut_read_data;
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cfg_bad) begin
            cfg_err <= 1'b1;
            state   <= S_SKIP;
          end else begin
            rptr     <= base + ADDR_W'(2);
            icnt     <= '0;
            lcnt     <= '0;
            col_last <= 4'(ncols - 16'(k_dim));
            orow     <= nrows - 16'(k_dim);
            state    <= S_FILL;
          end
        end

        S_FILL: begin
          if (icnt != k_dim) begin
            dut_sram_read_address <= rptr;
            rptr                  <= rptr + ADDR_W'(1);
            icnt                  <= icnt + 3'd1;
            tpipe[0]              <= T_ROW;
          end
          if (cur.row) begin
            lcnt <= lcnt + 3'd1;
            if (lcnt == k_dim - 3'd1) begin
              conv_go <= 1'b1;
              col_idx <= '0;
              state   <= S_SWEEP;
            end
          end
        end

        S_SWEEP: begin
          if (col_idx == col_last) begin
            conv_go <= 1'b0;
            dcnt    <= '0;
            if (CONV_LAT == 0) begin
              dut_sram_write_enable <= 1'b1;
              state                 <= S_WRITE;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            col_idx <= col_idx + 4'd1;
          end
        end

        S_DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            dut_sram_write_enable <= 1'b1;
            state                 <= S_WRITE;
          end else begin
            dcnt <= dcnt + 8'd1;
          end
        end

        S_WRITE: begin
          dut_sram_write_enable  <= 1'b0;
          dut_sram_write_address <= dut_sram_write_address + ADDR_W'(1);
          if (orow == 16'd0) begin
            state <= S_NEXT;
          end else begin
            orow                  <= orow - 16'd1;
            dut_sram_read_address <= rptr;
            rptr                  <= rptr + ADDR_W'(1);
            tpipe[0]              <= T_ROW;
            state                 <= S_ADV;
          end
        end

        S_ADV: begin
          if (cur.row) begin
            conv_go <= 1'b1;
            col_idx <= '0;
            state   <= S_SWEEP;
          end
        end

        S_SKIP: state <= S_NEXT;

        S_NEXT: begin
          base                  <= nxt_base;
          dut_sram_read_address <= nxt_base;
          dut_wmem_read_address <= '0;
          tpipe[0]              <= T_HDR0;
          hcnt                  <= 1'b1;
          state                 <= S_HDR;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// tb_conv_row_sequencer: randomized runs against an event-stream
// model of the sequencer, plus directed corner cases.
module tb_conv_row_sequencer;

  localparam int          AW   = 12;
  localparam int          KMAX = 5;
  localparam int          RDL  = 2;
  localparam int          CL   = 2;
  localparam logic [15:0] ENDM = 16'h00FF;
  localparam int          EV_LOAD = 0;
  localparam int          EV_GO   = 1;
  localparam int          EV_WR   = 2;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_b = 1'b1;
  logic          dut_run = 1'b0;
  logic          dut_busy;
  logic [AW-1:0] dut_sram_read_address;
  logic [15:0]   sram_dut_read_data;
  logic [AW-1:0] dut_wmem_read_address;
  logic [15:0]   wmem_dut_read_data;
  logic [2:0]    k_dim;
  logic          weight_load;
  logic          row_load;
  logic          conv_go;
  logic [3:0]    col_idx;
  logic          dut_sram_write_enable;
  logic [AW-1:0] dut_sram_write_address;
  logic          cfg_err;

  logic [15:0] smem [0:4095];
  logic [15:0] wmem [0:1];
  logic [15:0] sp [RDL];
  logic [15:0] wp [RDL];

  ev_t exp_q [$];
  int checks = 0;
  int errors = 0;
  int wb, oaddr, kk, end_base;
  logic exp_err;
  int n_go, n_wr, n_load, busy_len, last_wr;
  int cyc = 0;
  int last_go_cyc = 0;
  logic run_done = 1'b0;
  logic mon_en = 1'b0;
  logic prev_go = 1'b0;
  logic prev_load = 1'b0;
  logic prev_busy = 1'b0;
  logic [AW-1:0] hist [8];

  always #5 clk = ~clk;

  conv_row_sequencer #(
    .ADDR_W(AW), .KMAX(KMAX), .RD_LAT(RDL),
    .CONV_LAT(CL), .END_MARK(ENDM)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .dut_run(dut_run),
    .dut_busy(dut_busy),
    .dut_sram_read_address(dut_sram_read_address),
    .sram_dut_read_data(sram_dut_read_data),
    .dut_wmem_read_address(dut_wmem_read_address),
    .wmem_dut_read_data(wmem_dut_read_data),
    .k_dim(k_dim),
    .weight_load(weight_load),
    .row_load(row_load),
    .conv_go(conv_go),
    .col_idx(col_idx),
    .dut_sram_write_enable(dut_sram_write_enable),
    .dut_sram_write_address(dut_sram_write_address),
    .cfg_err(cfg_err)
  );

  // memories with RDL cycles of read latency
  always @(posedge clk) begin
    sp[0] <= smem[dut_sram_read_address];
    wp[0] <= wmem[dut_wmem_read_address[0]];
    for (int i = 1; i < RDL; i++) begin
      sp[i] <= sp[i-1];
      wp[i] <= wp[i-1];
    end
  end
  assign sram_dut_read_data = sp[RDL-1];
  assign wmem_dut_read_data = wp[RDL-1];

  task automatic chk(input string name, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic pop_cmp(input int kind, input int val,
                         input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event value %0d", name, val);
      return;
    end
    e = exp_q.pop_front();
    chk(name, kind * 65536 + val, e.kind * 65536 + e.val);
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic new_run(input int k);
    for (int i = 0; i < 4096; i++) smem[i] = 16'h0;
    wmem[0] = {13'($urandom), 3'(k)};
    wmem[1] = 16'($urandom);
    kk = k;
    wb = 0;
    oaddr = 0;
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  // matrix at wb: expected loads, column pulses and writes
  task automatic add_mat(input int nr, input int nc);
    logic [15:0] rows [$];
    smem[wb]   = 16'(nr);
    smem[wb+1] = 16'(nc);
    for (int i = 0; i < nr; i++) begin
      rows.push_back(16'($urandom));
      smem[wb+2+i] = rows[i];
    end
    if (kk == 0 || kk > KMAX || nc > 16 || kk > nr || kk > nc) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < kk; i++) push(EV_LOAD, int'(rows[i]));
      for (int r = 0; r <= nr - kk; r++) begin
        if (r > 0) push(EV_LOAD, int'(rows[kk-1+r]));
        for (int c = 0; c <= nc - kk; c++) push(EV_GO, c);
        push(EV_WR, oaddr);
        oaddr++;
      end
    end
    wb += 2 + nr;
  endtask

  task automatic add_end();
    smem[wb]   = ENDM;
    smem[wb+1] = 16'($urandom);
    end_base = wb;
  endtask

  task automatic launch(input int budget, input bit always_pulse);
    @(negedge clk);
    n_go = 0;
    n_wr = 0;
    n_load = 0;
    busy_len = 0;
    last_wr = -1;
    run_done = 1'b0;
    dut_run = 1'b1;
    @(posedge clk);
    #1;
    chk("start_busy", dut_busy, 1);
    chk("start_addr", dut_sram_read_address, 0);
    chk("start_cfg_err", cfg_err, 0);
    dut_run = 1'b0;
    for (int i = 0; i < budget && !run_done; i++) begin
      @(negedge clk);
      dut_run = dut_busy &&
                (always_pulse || $urandom_range(0, 5) == 0);
    end
    dut_run = 1'b0;
    if (!run_done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: busy after %0d cycles", budget);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = dut_sram_read_address;
    if (mon_en) begin
      if (!dut_busy)
        chk("idle_strobes", {weight_load, row_load, conv_go,
                             dut_sram_write_enable}, 0);
      if (row_load) begin
        n_load++;
        pop_cmp(EV_LOAD, int'(sram_dut_read_data), "row_load");
      end
      if (conv_go) begin
        n_go++;
        if (!prev_go) chk("go_after_load", prev_load, 1);
        chk("k_dim", k_dim, wmem[0][2:0]);
        pop_cmp(EV_GO, int'(col_idx), "conv_go");
        last_go_cyc = cyc;
      end
      if (dut_sram_write_enable) begin
        n_wr++;
        last_wr = int'(dut_sram_write_address);
        chk("write_spacing", cyc - last_go_cyc, CL + 1);
        pop_cmp(EV_WR, last_wr, "write");
      end
      if (weight_load) chk("weight_data", wmem_dut_read_data, wmem[1]);
      if (dut_busy) busy_len++;
      if (prev_busy && !dut_busy) begin
        chk("end_hdr_addr", hist[RDL+1], end_base);
        chk("cfg_err_end", cfg_err, exp_err);
        chk("events_left", exp_q.size(), 0);
        run_done = 1'b1;
      end
    end
    prev_go   = conv_go;
    prev_load = row_load;
    prev_busy = dut_busy;
  end

  initial begin
    int k, nm, idle_busy;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    for (int i = 0; i < 4096; i++) smem[i] = 16'h0;
    wmem[0] = 16'h0;
    wmem[1] = 16'h0;
    end_base = 0;
    #2 reset_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {dut_busy, dut_sram_read_address, dut_wmem_read_address, k_dim,
         weight_load, row_load, conv_go, col_idx, dut_sram_write_enable,
         dut_sram_write_address, cfg_err}, 0);
    reset_b = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // K=3, 5x5 then end marker at 7
    new_run(3);
    add_mat(5, 5);
    add_end();
    chk("model_end_5x5", end_base, 7);
    launch(2000, 1'b0);
    chk("go_5x5", n_go, 9);
    chk("wr_5x5", n_wr, 3);
    chk("last_wr_5x5", last_wr, 2);
    chk("load_5x5", n_load, 5);

    // K=1, 2x4
    new_run(1);
    add_mat(2, 4);
    add_end();
    launch(2000, 1'b0);
    chk("go_k1", n_go, 8);
    chk("wr_k1", n_wr, 2);
    chk("load_k1", n_load, 2);
    chk("cfg_err_k1", cfg_err, 0);

    // K=4: 3x3 skipped, 4x4 processed
    new_run(4);
    add_mat(3, 3);
    add_mat(4, 4);
    add_end();
    chk("model_end_skip", end_base, 11);
    launch(2000, 1'b0);
    chk("wr_skip", n_wr, 1);
    chk("last_wr_skip", last_wr, 0);
    chk("go_skip", n_go, 1);
    chk("cfg_err_skip", cfg_err, 1);
    repeat (3) @(negedge clk);
    chk("cfg_err_sticky", cfg_err, 1);

    for (int r = 0; r < 12; r++) begin
      k = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7)
                                      : $urandom_range(1, 5);
      new_run(k);
      nm = $urandom_range(1, 3);
      for (int m = 0; m < nm; m++)
        add_mat($urandom_range(1, 6), $urandom_range(1, 17));
      add_end();
      launch(5000, 1'b0);
    end

    // reset in the middle of a sweep
    new_run(3);
    add_mat(6, 7);
    add_end();
    @(negedge clk);
    run_done = 1'b0;
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    for (int i = 0; i < 500 && !conv_go; i++) @(negedge clk);
    chk("reached_sweep", conv_go, 1);
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset_b = 1'b0;
    #1;
    chk("abort_outputs",
        {dut_busy, dut_sram_read_address, dut_wmem_read_address, k_dim,
         weight_load, row_load, conv_go, col_idx, dut_sram_write_enable,
         dut_sram_write_address, cfg_err}, 0);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    new_run(3);
    add_mat(5, 5);
    add_end();
    launch(2000, 1'b0);
    chk("go_restart", n_go, 9);
    chk("wr_restart", n_wr, 3);

    // end marker first, dut_run held during busy
    new_run(2);
    add_end();
    launch(200, 1'b1);
    chk("busy_len_end", busy_len, RDL + 1);
    chk("wr_end", n_wr, 0);
    idle_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (dut_busy) idle_busy++;
    end
    chk("no_restart", idle_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
